alu_seq: RTL

Parametrised, handshaked successor to the team's combinational 4-bit ALU. It takes WIDTH-bit operands and a 4-bit opcode over a valid/ready input channel, and returns a registered result plus four flags over a valid/ready output channel. All single-cycle operations take one cycle; multiply is a multi-cycle shift-add. It sits between the instruction decoder and the register-file write-back stage.

---
 rtl/alu_seq.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result and flags; multiply is a
// WIDTH-cycle shift-add built only when ALU_MUL_EN is defined.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Sel,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Negative,
  output logic             Zero,
  output logic             Err
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_INC = 4'd6,
    OP_DEC = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_SAR = 4'd10,
    OP_MUL = 4'd11
  } op_t;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;
  logic   w_in_ready;
  logic   w_out_valid;
  logic   w_accept;
  logic   w_is_mul;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_neg;
  logic             r_zero;
  logic             r_err;

  logic [WIDTH-1:0] w_rhs;
  logic [WIDTH:0]   w_add_ext;
  logic [WIDTH:0]   w_sub_ext;
  logic [SW-1:0]    w_sh;
  logic [WIDTH:0]   w_shl_ext;
  logic [WIDTH:0]   w_shr_ext;
  logic [WIDTH:0]   w_sar_ext;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_err;

  assign w_accept = (r_state == IDLE) && InValid;

`ifdef ALU_MUL_EN
  assign w_is_mul = (op_t'(Sel) == OP_MUL);
`else
  assign w_is_mul = 1'b0;
`endif

  // INC/DEC reuse the adder and subtractor with a constant right-hand side.
  assign w_rhs     = ((op_t'(Sel) == OP_INC) || (op_t'(Sel) == OP_DEC)) ? WIDTH'(1) : B;
  assign w_add_ext = {1'b0, A} + {1'b0, w_rhs};
  assign w_sub_ext = {1'b0, A} - {1'b0, w_rhs};

  // One guard bit beside A catches the last bit shifted out; it is zero for
  // a zero shift amount without needing a special case.
  assign w_sh      = B[SW-1:0];
  assign w_shl_ext = {1'b0, A} << w_sh;
  assign w_shr_ext = {A, 1'b0} >> w_sh;
  assign w_sar_ext = $signed({A, 1'b0}) >>> w_sh;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (op_t'(Sel))
      OP_ADD, OP_INC: begin
        w_res   = w_add_ext[WIDTH-1:0];
        w_carry = w_add_ext[WIDTH];
        w_ovf   = (A[WIDTH-1] == w_rhs[WIDTH-1]) && (w_add_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        w_res   = w_sub_ext[WIDTH-1:0];
        w_carry = w_sub_ext[WIDTH];
        w_ovf   = (A[WIDTH-1] != w_rhs[WIDTH-1]) && (w_sub_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      OP_XOR: w_res = A ^ B;
      OP_NOT: w_res = ~A;
      OP_SHL: begin
        w_res   = w_shl_ext[WIDTH-1:0];
        w_carry = w_shl_ext[WIDTH];
      end
      OP_SHR: begin
        w_res   = w_shr_ext[WIDTH:1];
        w_carry = w_shr_ext[0];
      end
      OP_SAR: begin
        w_res   = w_sar_ext[WIDTH:1];
        w_carry = w_sar_ext[0];
      end
      default: w_err = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [SW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_result_hi;
  logic [WIDTH:0]     w_mul_add;
  logic [2*WIDTH-1:0] w_prod_next;
  logic               w_mul_last;

  // Product register holds {partial high, remaining multiplier bits}.
  assign w_mul_add   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                       (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_next = {w_mul_add, r_prod[WIDTH-1:1]};
  assign w_mul_last  = (r_cnt == SW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand <= A;
      r_prod  <= {{WIDTH{1'b0}}, B};
      r_cnt   <= '0;
    end else if (r_state == MUL) begin
      r_prod <= w_prod_next;
      r_cnt  <= w_mul_last ? '0 : r_cnt + SW'(1);
    end
  end

  assign ResultHi = r_result_hi;
`else
  assign ResultHi = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
`ifdef ALU_MUL_EN
      r_result_hi <= '0;
`endif
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_res;
      r_carry  <= w_carry;
      r_ovf    <= w_ovf;
      r_neg    <= w_res[WIDTH-1];
      r_zero   <= (w_res == '0);
      r_err    <= w_err;
`ifdef ALU_MUL_EN
      r_result_hi <= '0;
    end else if ((r_state == MUL) && w_mul_last) begin
      r_result    <= w_prod_next[WIDTH-1:0];
      r_result_hi <= w_prod_next[2*WIDTH-1:WIDTH];
      r_carry     <= (w_prod_next[2*WIDTH-1:WIDTH] != '0);
      r_ovf       <= 1'b0;
      r_neg       <= w_prod_next[WIDTH-1];
      r_zero      <= (w_prod_next == '0);
      r_err       <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (InValid) begin
          w_state_nxt = DONE;
`ifdef ALU_MUL_EN
          if (w_is_mul) begin
            w_state_nxt = MUL;
          end
`endif
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        if (w_mul_last) begin
          w_state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        w_out_valid = 1'b1;
        if (OutReady) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign InReady  = w_in_ready;
  assign OutValid = w_out_valid;
  assign Result   = r_result;
  assign CarryOut = r_carry;
  assign Overflow = r_ovf;
  assign Negative = r_neg;
  assign Zero     = r_zero;
  assign Err      = r_err;

endmodule
